parallel_to_serial_stream: RTL and testbench

- Counterpart of the serializer-to-parallel front end of the FIR/convolution path.
- Takes one WIDTH-element block from the convolver output bus and replays it as a serial audio sample stream, one element per sample_tick.
- Two-entry block buffer (active + pending) lets the convolver deliver the next block while the current one drains.
- Sits between the convolution output and the downstream effect chain / DAC path.

---
 rtl/parallel_to_serial_stream.sv | 97 +++++++++
 tb/tb_parallel_to_serial_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial_stream.sv
// Replays one WIDTH-element block as a serial sample stream, one element per sample_tick (1-cycle registered latency).
// Two-entry buffer (active + pending); parallel_ready = !pending_full, offers while not ready are dropped and flagged.
module parallel_to_serial_stream #(
  parameter int XLEN  = 16,
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        parallel_valid,
  input  logic [WIDTH-1:0][XLEN-1:0]  parallel_data,
  output logic                        parallel_ready,
  input  logic                        sample_tick,
  output logic                        serial_valid,
  output logic [XLEN-1:0]             serial_data,
  output logic                        underrun,
  output logic                        overrun
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state;
  logic [WIDTH-1:0][XLEN-1:0]   active;
  logic [WIDTH-1:0][XLEN-1:0]   pending;
  logic                         pending_full;
  logic [IW-1:0]                idx;

  logic accept;
  logic last_tick;
  logic to_pending;

  assign accept     = parallel_valid && parallel_ready;
  assign last_tick  = (state == STREAM) && sample_tick && (idx == LAST_IDX);
  // While streaming, any accept except the one coinciding with the last-element tick lands in pending.
  assign to_pending = (state == STREAM) && accept && !last_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      active         <= '0;
      pending        <= '0;
      pending_full   <= 1'b0;
      idx            <= '0;
      parallel_ready <= 1'b1;
      serial_valid   <= 1'b0;
      serial_data    <= '0;
      underrun       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      serial_valid <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= parallel_valid && !parallel_ready;

      case (state)
        IDLE: begin
          underrun <= sample_tick;
          if (accept) begin
            active <= parallel_data;
            idx    <= '0;
            state  <= STREAM;
          end
        end

        STREAM: begin
          if (sample_tick) begin
            serial_valid <= 1'b1;
            serial_data  <= active[idx];
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (pending_full) begin
                active         <= pending;
                pending_full   <= 1'b0;
                parallel_ready <= 1'b1;
              end else if (accept) begin
                active <= parallel_data;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
          if (to_pending) begin
            pending        <= parallel_data;
            pending_full   <= 1'b1;
            parallel_ready <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Bench for parallel_to_serial_stream: directed scenarios plus random traffic, checked every cycle against a sample-queue model.
module tb_parallel_to_serial_stream;

  localparam int XLEN  = 16;
  localparam int WIDTH = 16;
  typedef logic [WIDTH-1:0][XLEN-1:0] blk_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            parallel_valid = 1'b0;
  blk_t            parallel_data = '0;
  logic            parallel_ready;
  logic            sample_tick = 1'b0;
  logic            serial_valid;
  logic [XLEN-1:0] serial_data;
  logic            underrun;
  logic            overrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [XLEN-1:0] out_q[$];

  always #5 clk = ~clk;

  parallel_to_serial_stream #(.XLEN(XLEN), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
    .parallel_ready (parallel_ready),
    .sample_tick    (sample_tick),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .underrun       (underrun),
    .overrun        (overrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every buffered-but-unsent sample in one flat queue.
  // Blocks held = ceil(samples / WIDTH); the source may offer only while fewer than two are held.
  logic [XLEN-1:0] mq[$];
  bit              m_ready = 1'b1;
  bit              m_sv = 1'b0;
  bit              m_ur = 1'b0;
  bit              m_ov = 1'b0;
  logic [XLEN-1:0] m_sd = '0;
  bit              m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_sv = 1'b0;
      m_ur = 1'b0;
      m_ov = 1'b0;
      m_sd = '0;
    end else begin
      m_acc = parallel_valid && m_ready;
      m_ov  = parallel_valid && !m_ready;
      m_sv  = 1'b0;
      m_ur  = 1'b0;
      if (sample_tick) begin
        if (mq.size() > 0) begin
          m_sd = mq.pop_front();
          m_sv = 1'b1;
        end else begin
          m_ur = 1'b1;
        end
      end
      if (m_acc)
        for (int i = 0; i < WIDTH; i++) mq.push_back(parallel_data[i]);
      m_ready = ((mq.size() + WIDTH - 1) / WIDTH) < 2;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("serial_valid", serial_valid, m_sv);
      check("serial_data", serial_data, m_sd);
      check("underrun", underrun, m_ur);
      check("overrun", overrun, m_ov);
      check("parallel_ready", parallel_ready, m_ready);
      if (serial_valid) out_q.push_back(serial_data);
    end
  end

  // Inputs are applied 2 time units after a rising edge and consumed by the next one.
  task automatic step(input logic tk, input logic v, input blk_t d);
    sample_tick    = tk;
    parallel_valid = v;
    parallel_data  = d;
    @(posedge clk);
    #2;
    sample_tick    = 1'b0;
    parallel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      step(1'b1, 1'b0, '0);
      idle(gap);
    end
  endtask

  function automatic blk_t mkblk(input logic [XLEN-1:0] base);
    blk_t b;
    for (int i = 0; i < WIDTH; i++) b[i] = base + XLEN'(i);
    return b;
  endfunction

  function automatic blk_t rndblk();
    blk_t b;
    for (int i = 0; i < WIDTH; i++) b[i] = XLEN'($urandom);
    return b;
  endfunction

  blk_t a, b, c, d, e, f, g, h;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", parallel_ready, 1);
    check("rst_serial_valid", serial_valid, 0);
    check("rst_serial_data", serial_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Ticks with nothing loaded.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      check("t2_underrun", underrun, 1);
      check("t2_serial_valid", serial_valid, 0);
      check("t2_serial_data", serial_data, 0);
      idle(2);
    end

    // Single block 0x0001..0x0010, ticks 4 cycles apart.
    out_q.delete();
    a = mkblk(16'h0001);
    step(1'b0, 1'b1, a);
    idle(1);
    step(1'b1, 1'b0, '0);
    check("t1_first_valid", serial_valid, 1);
    check("t1_first_data", serial_data, 16'h0001);
    idle(3);
    ticks(15, 3);
    idle(2);
    check("t1_count", out_q.size(), 16);
    for (int i = 0; i < WIDTH && i < out_q.size(); i++)
      check("t1_elem", out_q[i], 32'(i + 1));
    check("t1_ready", parallel_ready, 1);
    step(1'b1, 1'b0, '0);
    check("t1_idle_underrun", underrun, 1);
    idle(2);

    // Pending fill, overrun drop, seamless handoff.
    out_q.delete();
    a = mkblk(16'h0A00);
    b = mkblk(16'h0B00);
    c = mkblk(16'h0C00);
    step(1'b0, 1'b1, a);
    idle(1);
    ticks(2, 1);
    step(1'b1, 1'b1, b);
    check("t3_ready_low", parallel_ready, 0);
    step(1'b0, 1'b1, c);
    check("t3_overrun", overrun, 1);
    ticks(29, 1);
    idle(2);
    check("t3_count", out_q.size(), 32);
    for (int i = 0; i < 32 && i < out_q.size(); i++)
      check("t3_elem", out_q[i], (i < 16) ? 32'(16'h0A00 + i) : 32'(16'h0B00 + i - 16));

    // Offer coinciding with the last-element tick goes straight to active.
    d = mkblk(16'h0D00);
    e = mkblk(16'h0E00);
    step(1'b0, 1'b1, d);
    idle(1);
    ticks(15, 1);
    step(1'b1, 1'b1, e);
    check("t4_last_data", serial_data, 16'h0D0F);
    idle(1);
    step(1'b1, 1'b0, '0);
    check("t4_e0_valid", serial_valid, 1);
    check("t4_e0_data", serial_data, 16'h0E00);
    check("t4_no_underrun", underrun, 0);
    idle(1);
    ticks(15, 1);
    idle(2);

    // Asynchronous reset mid-block with pending full.
    f = mkblk(16'h0F00);
    g = mkblk(16'h1000);
    step(1'b0, 1'b1, f);
    idle(1);
    ticks(5, 1);
    step(1'b0, 1'b1, g);
    check("t5_ready_low", parallel_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst_ready", parallel_ready, 1);
    check("t5_rst_valid", serial_valid, 0);
    check("t5_rst_data", serial_data, 0);
    check("t5_rst_underrun", underrun, 0);
    check("t5_rst_overrun", overrun, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle(1);
    step(1'b1, 1'b0, '0);
    check("t5_post_underrun", underrun, 1);
    check("t5_post_valid", serial_valid, 0);
    idle(1);

    // Negative samples pass bit-exact.
    h = rndblk();
    h[0] = 16'h8000;
    h[1] = 16'hFFFF;
    step(1'b0, 1'b1, h);
    idle(1);
    step(1'b1, 1'b0, '0);
    check("t6_8000", serial_data, 16'h8000);
    idle(1);
    step(1'b1, 1'b0, '0);
    check("t6_ffff", serial_data, 16'hFFFF);
    idle(1);
    ticks(14, 1);
    idle(2);

    // Random traffic, including back-to-back ticks.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), rndblk());
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
